// File: rtl/counter_v2.sv
// counter_v2: bounded up/down counter with load, terminal-count pulse and a
// sticky bound-crossing flag. The count range is 0..limit (inclusive), with
// limit sampled every cycle. At a bound the counter either wraps to the
// opposite bound or holds, depending on SATURATE.
//
// Control priority at each rising edge: rst low > load > en > hold.
// All outputs come straight from flops; there is no input-to-output
// combinational path.
module counter_v2 #(
   parameter int          WIDTH     = 10,  // 2..32
   parameter int          SATURATE  = 0,   // 0 = wrap at bounds, 1 = hold at bounds
   parameter int unsigned RESET_VAL = 0    // count loaded by reset
) (
   input  logic             clk,
   input  logic             rst,       // synchronous, active-low
   input  logic             en,
   input  logic             mode,      // 1 = up, 0 = down
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ZERO      = '0;
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q,  tc_d;
   logic             ovf_q, ovf_d;

   // Next-state logic: load clamps to limit; an enabled step either moves by
   // one or, at a bound, wraps/holds and raises both tc and ovf. The up-bound
   // test is cnt >= limit (never cnt+1 > limit), so limit = all-ones cannot
   // overflow the comparison. A count left above a lowered limit is pulled
   // back to limit on a down step without counting as a bound event.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (load) begin
         cnt_d = (load_val > limit) ? limit : load_val;
         ovf_d = 1'b0;
      end else if (en) begin
         if (mode) begin
            if (cnt_q < limit) begin
               cnt_d = cnt_q + ONE;
            end else begin
               cnt_d = (SATURATE != 0) ? limit : ZERO;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end
         end else begin
            if (cnt_q > limit) begin
               cnt_d = limit;
            end else if (cnt_q != ZERO) begin
               cnt_d = cnt_q - ONE;
            end else begin
               cnt_d = (SATURATE != 0) ? ZERO : limit;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset overriding everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= RESET_CNT;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_v2.sv
// Testbench for counter_v2. Two instances share one input stream: u_wrap
// (SATURATE=0, RESET_VAL=0) and u_sat (SATURATE=1, RESET_VAL=600). A
// table of vectors gives hand-computed expectations for u_wrap, short
// directed sequences cover saturation and out-of-range reset values, and a
// random phase compares both instances against an arithmetic model.
module tb_counter_v2;

  localparam int W    = 10;
  localparam int RV_S = 600;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] limit = '0;

  logic [W-1:0] cnt_w, cnt_s;
  logic         tc_w, tc_s, ovf_w, ovf_s;

  int checks = 0;
  int failures = 0;

  // model state, index 0 = wrap instance, 1 = saturating instance
  int m_cnt[2];
  int m_tc[2];
  int m_ovf[2];

  typedef struct {
    bit rst;
    bit en;
    bit mode;
    bit load;
    int lv;
    int lim;
    int cnt;
    int tc;
    int ovf;
  } vec_t;

  vec_t vecs[$];

  counter_v2 #(.WIDTH(W), .SATURATE(0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w)
  );

  counter_v2 #(.WIDTH(W), .SATURATE(1), .RESET_VAL(RV_S)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit m, input bit l,
                       input int lv, input int lim);
    rst      = r;
    en       = e;
    mode     = m;
    load     = l;
    load_val = W'(lv);
    limit    = W'(lim);
  endtask

  // Reference: the count rules stated as plain integer arithmetic.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int c;
      int lim;
      int lv;
      c   = m_cnt[k];
      lim = int'(limit);
      lv  = int'(load_val);
      if (!rst) begin
        m_cnt[k] = (k == 1) ? RV_S : 0;
        m_tc[k]  = 0;
        m_ovf[k] = 0;
      end else if (load) begin
        m_cnt[k] = (lv < lim) ? lv : lim;
        m_tc[k]  = 0;
        m_ovf[k] = 0;
      end else if (!en) begin
        m_tc[k] = 0;
      end else if (mode) begin
        if (c + 1 <= lim) begin
          m_cnt[k] = c + 1;
          m_tc[k]  = 0;
        end else begin
          m_cnt[k] = (k == 1) ? lim : 0;
          m_tc[k]  = 1;
          m_ovf[k] = 1;
        end
      end else begin
        if (c > lim) begin
          m_cnt[k] = lim;
          m_tc[k]  = 0;
        end else if (c - 1 >= 0) begin
          m_cnt[k] = c - 1;
          m_tc[k]  = 0;
        end else begin
          m_cnt[k] = (k == 1) ? 0 : lim;
          m_tc[k]  = 1;
          m_ovf[k] = 1;
        end
      end
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then sample
  // the DUTs 1 time unit after the edge and compare against the model.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_cnt_wrap", int'(cnt_w), m_cnt[0]);
    chk("model_tc_wrap",  int'(tc_w),  m_tc[0]);
    chk("model_ovf_wrap", int'(ovf_w), m_ovf[0]);
    chk("model_cnt_sat",  int'(cnt_s), m_cnt[1]);
    chk("model_tc_sat",   int'(tc_s),  m_tc[1]);
    chk("model_ovf_sat",  int'(ovf_s), m_ovf[1]);
  endtask

  task automatic chk_sat(input string name, input int c, input int t, input int o);
    chk({name, "_cnt"}, int'(cnt_s), c);
    chk({name, "_tc"},  int'(tc_s),  t);
    chk({name, "_ovf"}, int'(ovf_s), o);
  endtask

  initial begin
    m_cnt = '{0, 0};
    m_tc  = '{0, 0};
    m_ovf = '{0, 0};

    // rst en mode load lv lim -> cnt tc ovf (expected for u_wrap)
    vecs.push_back('{0, 1, 1, 1, 7,    5,    0,    0, 0}); // reset beats load/en
    vecs.push_back('{0, 1, 1, 1, 7,    5,    0,    0, 0});
    vecs.push_back('{1, 1, 1, 0, 0,    5,    1,    0, 0}); // up wrap at limit 5
    vecs.push_back('{1, 1, 1, 0, 0,    5,    2,    0, 0});
    vecs.push_back('{1, 1, 1, 0, 0,    5,    3,    0, 0});
    vecs.push_back('{1, 1, 1, 0, 0,    5,    4,    0, 0});
    vecs.push_back('{1, 1, 1, 0, 0,    5,    5,    0, 0});
    vecs.push_back('{1, 1, 1, 0, 0,    5,    0,    1, 1});
    vecs.push_back('{1, 1, 1, 0, 0,    5,    1,    0, 1});
    vecs.push_back('{1, 0, 0, 1, 0,    1023, 0,    0, 0}); // down wrap full range
    vecs.push_back('{1, 1, 0, 0, 0,    1023, 1023, 1, 1});
    vecs.push_back('{1, 1, 0, 0, 0,    1023, 1022, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 0,    500,  0,    0, 0}); // build cnt=10, ovf=1
    vecs.push_back('{1, 1, 0, 0, 0,    500,  500,  1, 1});
    vecs.push_back('{1, 1, 0, 0, 0,    11,   11,   0, 1}); // lowered limit, down
    vecs.push_back('{1, 1, 0, 0, 0,    500,  10,   0, 1});
    vecs.push_back('{1, 1, 0, 1, 900,  500,  500,  0, 0}); // load clamps, clears ovf
    vecs.push_back('{1, 0, 0, 1, 7,    1023, 7,    0, 0});
    vecs.push_back('{1, 1, 1, 0, 0,    3,    0,    1, 1}); // lowered limit, up
    vecs.push_back('{1, 0, 0, 1, 7,    1023, 7,    0, 0});
    vecs.push_back('{1, 1, 0, 0, 0,    3,    3,    0, 0}); // lowered limit, down
    vecs.push_back('{1, 0, 1, 0, 0,    3,    3,    0, 0}); // hold
    vecs.push_back('{1, 1, 1, 0, 0,    0,    0,    1, 1}); // limit 0, up
    vecs.push_back('{1, 1, 1, 0, 0,    0,    0,    1, 1});
    vecs.push_back('{1, 1, 0, 0, 0,    0,    0,    1, 1}); // limit 0, down
    vecs.push_back('{1, 1, 1, 0, 0,    5,    1,    0, 1}); // mode changes
    vecs.push_back('{1, 1, 0, 0, 0,    5,    0,    0, 1});
    vecs.push_back('{1, 1, 0, 0, 0,    5,    5,    1, 1});
    vecs.push_back('{0, 1, 0, 0, 0,    5,    0,    0, 0}); // reset mid-count
    vecs.push_back('{1, 0, 0, 1, 1023, 1023, 1023, 0, 0}); // full-range up wrap
    vecs.push_back('{1, 1, 1, 0, 0,    1023, 0,    1, 1});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].lv, vecs[i].lim);
      step();
      chk($sformatf("vec%0d_cnt", i), int'(cnt_w), vecs[i].cnt);
      chk($sformatf("vec%0d_tc", i),  int'(tc_w),  vecs[i].tc);
      chk($sformatf("vec%0d_ovf", i), int'(ovf_w), vecs[i].ovf);
    end

    // saturation: from cnt=4, limit 5, three up steps
    drive(1, 0, 1, 1, 4, 5);
    step();
    chk_sat("sat_load", 4, 0, 0);
    drive(1, 1, 1, 0, 0, 5);
    step();
    chk_sat("sat_up1", 5, 0, 0);
    step();
    chk_sat("sat_up2", 5, 1, 1);
    step();
    chk_sat("sat_up3", 5, 1, 1);

    // reset value above limit: up step is a bound event
    drive(0, 0, 1, 0, 0, 500);
    step();
    chk_sat("rv_reset", RV_S, 0, 0);
    drive(1, 1, 1, 0, 0, 500);
    step();
    chk_sat("rv_up", 500, 1, 1);

    // reset value above limit: down step clamps without a bound event
    drive(0, 1, 0, 0, 0, 500);
    step();
    chk_sat("rv_reset2", RV_S, 0, 0);
    drive(1, 1, 0, 0, 0, 500);
    step();
    chk_sat("rv_down", 500, 0, 0);

    // randomized phase, checked against the model inside step()
    begin
      int lim_r;
      lim_r = 7;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 4))
            0:       lim_r = 0;
            1:       lim_r = 1;
            2:       lim_r = 1023;
            3:       lim_r = int'($urandom_range(2, 20));
            default: lim_r = int'($urandom_range(0, 1023));
          endcase
        end
        drive($urandom_range(0, 49) != 0,
              $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0,
              int'($urandom_range(0, 1023)),
              lim_r);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
